// File: rtl/he_stream_eq_if.sv
// Pixel stream bundle for he_stream_eq: input stream (valid/ready/pixel) and
// remapped output stream (valid/ready/pixel).
interface he_stream_eq_if #(
  parameter int unsigned PIX_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_pixel;

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_pixel
  );

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_pixel
  );
endinterface

// File: rtl/he_stream_eq.sv
// Streaming histogram equaliser: histogram one frame, build the min-normalised
// CDF mapping LUT with a restoring divider, then remap a replay of the frame.
module he_stream_eq #(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned IMG_W      = 660,
  parameter int unsigned IMG_H      = 440,
  parameter int unsigned NUM_PIXELS = IMG_W * IMG_H,
  parameter int unsigned CNT_W      = 19
) (
  input  logic          clk,
  input  logic          reset,
  he_stream_eq_if.slave bus,
  output logic          lut_valid,
  output logic          frame_done,
  output logic [2:0]    phase
);
  localparam int unsigned L      = 1 << PIX_W;
  localparam int unsigned PW     = CNT_W + PIX_W;
  localparam int unsigned STEP_W = $clog2(PIX_W + 1);

  localparam logic [CNT_W-1:0]  NUM_PIX   = CNT_W'(NUM_PIXELS);
  localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(NUM_PIXELS - 1);
  localparam logic [PIX_W-1:0]  LAST_BIN  = PIX_W'(L - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(PIX_W);

  typedef enum logic [2:0] {
    S_CLEAR   = 3'd0,
    S_COLLECT = 3'd1,
    S_CDF     = 3'd2,
    S_LUT     = 3'd3,
    S_MAP     = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Histogram bins are overwritten in place with the running CDF.
  logic [CNT_W-1:0]  hist [L];
  logic [PIX_W-1:0]  lut  [L];

  logic [PIX_W-1:0]  bin;
  logic [CNT_W-1:0]  pix_cnt;
  logic [STEP_W-1:0] step;
  logic [CNT_W-1:0]  acc;
  logic [CNT_W-1:0]  cdf_min;
  logic              min_found;
  logic [PW-1:0]     rem;
  logic [PW-1:0]     dsh;
  logic [PIX_W-1:0]  quo;
  logic              out_valid_q;
  logic [PIX_W-1:0]  out_pixel_q;

  logic              in_rdy;
  logic              in_fire;
  logic              out_fire;
  logic              last_in;
  logic              final_out;
  logic [CNT_W-1:0]  cdf_next;
  logic [CNT_W-1:0]  denom;
  logic [CNT_W-1:0]  diff;
  logic [PW-1:0]     prod;
  logic              ge;
  logic [PIX_W-1:0]  quo_next;
  logic [PIX_W-1:0]  lut_val;

  assign in_rdy = (state == S_COLLECT) ||
                  ((state == S_MAP) && (pix_cnt != NUM_PIX) &&
                   (!out_valid_q || bus.out_ready));
  assign in_fire   = bus.in_valid && in_rdy;
  assign out_fire  = out_valid_q && bus.out_ready;
  assign last_in   = (pix_cnt == LAST_PIX);
  assign final_out = out_fire && (pix_cnt == NUM_PIX);

  // CDF step and divider datapath
  assign cdf_next = acc + hist[bin];
  assign denom    = NUM_PIX - cdf_min;
  assign diff     = (hist[bin] >= cdf_min) ? (hist[bin] - cdf_min) : '0;
  assign prod     = PW'(diff) * PW'(L - 1);
  assign ge       = (rem >= dsh);
  assign quo_next = (quo << 1) | PIX_W'(ge);
  assign lut_val  = (denom == '0) ? bin : quo_next;

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pixel = out_pixel_q;
  assign phase         = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_CLEAR:   if (bin == LAST_BIN) state_nxt = S_COLLECT;
      S_COLLECT: if (in_fire && last_in) state_nxt = S_CDF;
      S_CDF:     if (bin == LAST_BIN) state_nxt = S_LUT;
      S_LUT:     if ((bin == LAST_BIN) && (step == LAST_STEP)) state_nxt = S_MAP;
      S_MAP:     if (final_out) state_nxt = S_CLEAR;
      default:   state_nxt = S_CLEAR;
    endcase
  end

  // Control counters, divider registers and output stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin         <= '0;
      pix_cnt     <= '0;
      step        <= '0;
      acc         <= '0;
      cdf_min     <= '0;
      min_found   <= 1'b0;
      rem         <= '0;
      dsh         <= '0;
      quo         <= '0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      lut_valid   <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        S_CLEAR: begin
          bin       <= bin + PIX_W'(1);
          acc       <= '0;
          cdf_min   <= '0;
          min_found <= 1'b0;
        end
        S_COLLECT: begin
          if (in_fire) pix_cnt <= last_in ? '0 : pix_cnt + CNT_W'(1);
        end
        S_CDF: begin
          acc <= cdf_next;
          if (!min_found && (cdf_next != '0)) begin
            cdf_min   <= cdf_next;
            min_found <= 1'b1;
          end
          bin <= bin + PIX_W'(1);
        end
        S_LUT: begin
          if (step == '0) begin
            rem  <= prod;
            dsh  <= PW'(denom) << (PIX_W - 1);
            quo  <= '0;
            step <= step + STEP_W'(1);
          end else begin
            if (ge) rem <= rem - dsh;
            dsh <= dsh >> 1;
            quo <= quo_next;
            if (step == LAST_STEP) begin
              step <= '0;
              bin  <= bin + PIX_W'(1);
              if (bin == LAST_BIN) lut_valid <= 1'b1;
            end else begin
              step <= step + STEP_W'(1);
            end
          end
        end
        S_MAP: begin
          if (in_fire) begin
            out_valid_q <= 1'b1;
            out_pixel_q <= lut[bus.in_pixel];
            pix_cnt     <= pix_cnt + CNT_W'(1);
          end else if (out_fire) begin
            out_valid_q <= 1'b0;
          end
          if (final_out) begin
            frame_done <= 1'b1;
            lut_valid  <= 1'b0;
            pix_cnt    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Histogram/CDF and LUT storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    unique case (state)
      S_CLEAR:   hist[bin] <= '0;
      S_COLLECT: if (in_fire) hist[bus.in_pixel] <= hist[bus.in_pixel] + CNT_W'(1);
      S_CDF:     hist[bin] <= cdf_next;
      S_LUT:     if (step == LAST_STEP) lut[bin] <= lut_val;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_he_stream_eq.sv
// Bench for he_stream_eq with a 4x4 frame of 3-bit pixels: directed frames,
// per-cycle comparison against a frame-level equalisation model.
module tb_he_stream_eq;
  localparam int PIX_W = 3;
  localparam int L     = 8;
  localparam int NUM   = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       lut_valid;
  logic       frame_done;
  logic [2:0] phase;

  he_stream_eq_if #(.PIX_W(PIX_W)) bus ();

  he_stream_eq #(
    .PIX_W(PIX_W), .IMG_W(4), .IMG_H(4), .CNT_W(5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .lut_valid (lut_valid),
    .frame_done(frame_done),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endfunction

  // Frame-level model state
  int m_hist [L];
  int m_lut  [L];
  int m_coll, m_in_map, m_out_cnt;
  int q[$];
  int out_log[$];
  int prev_phase, ph_len, ph, exp_rdy, hold_val;
  bit prev_in_fire, prev_final, hold_pend, in_fire, out_fire;

  // Stimulus controls shared with the out_ready driver
  bit rand_ready = 0;
  bit stall_req  = 0;
  bit stall_done = 0;
  int stall_left = 0;

  function automatic void build_model();
    int cdf [L];
    int run, cmin, d;
    run  = 0;
    cmin = 0;
    for (int v = 0; v < L; v++) begin
      run += m_hist[v];
      cdf[v] = run;
      if (cmin == 0 && run != 0) cmin = run;
    end
    d = NUM - cmin;
    for (int v = 0; v < L; v++)
      m_lut[v] = (d == 0) ? v : (((cdf[v] < cmin) ? 0 : cdf[v] - cmin) * (L - 1)) / d;
  endfunction

  // Compare process: outputs are stable at the falling edge
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      m_coll = 0; m_in_map = 0; m_out_cnt = 0;
      prev_phase = 0; ph_len = 0;
      prev_in_fire = 0; prev_final = 0; hold_pend = 0;
      for (int v = 0; v < L; v++) m_hist[v] = 0;
    end else begin
      ph = int'(phase);
      if (ph != prev_phase) begin
        chk("phase_seq", ph, (prev_phase + 1) % 5);
        if (prev_phase == 1) chk("collect_count", m_coll, NUM);
        if (prev_phase == 2) chk("cdf_len", ph_len, L);
        if (prev_phase == 3) chk("lut_len", ph_len, L * (PIX_W + 1));
        ph_len = 0;
      end
      ph_len++;
      if (ph == 1 && prev_phase != 1) begin
        for (int v = 0; v < L; v++) m_hist[v] = 0;
        m_coll = 0; m_in_map = 0; m_out_cnt = 0;
      end
      if (ph == 4 && prev_phase != 4) build_model();

      exp_rdy = (ph == 1) ? 1 :
                (ph == 4) ? int'(m_in_map < NUM && (!bus.out_valid || bus.out_ready)) : 0;
      chk("in_ready", int'(bus.in_ready), exp_rdy);
      chk("lut_valid", int'(lut_valid), int'(ph == 4));
      chk("frame_done", int'(frame_done), int'(prev_final));
      if (ph != 4) chk("out_valid_idle", int'(bus.out_valid), 0);
      if (prev_in_fire) chk("latency_valid", int'(bus.out_valid), 1);
      if (hold_pend) begin
        chk("hold_valid", int'(bus.out_valid), 1);
        chk("hold_pixel", int'(bus.out_pixel), hold_val);
      end
      if (frame_done) chk("queue_empty", q.size(), 0);

      in_fire    = bus.in_valid && bus.in_ready;
      out_fire   = bus.out_valid && bus.out_ready;
      prev_final = 0;
      if (ph == 1 && in_fire) begin
        m_hist[int'(bus.in_pixel)]++;
        m_coll++;
      end
      if (ph == 4) begin
        if (out_fire) begin
          if (q.size() == 0) chk("out_extra", 1, 0);
          else chk("out_pixel", int'(bus.out_pixel), q.pop_front());
          out_log.push_back(int'(bus.out_pixel));
          m_out_cnt++;
          if (m_out_cnt == NUM) prev_final = 1;
        end
        if (in_fire) begin
          q.push_back(m_lut[int'(bus.in_pixel)]);
          m_in_map++;
        end
        hold_pend    = bus.out_valid && !bus.out_ready;
        hold_val     = int'(bus.out_pixel);
        prev_in_fire = in_fire;
      end else begin
        hold_pend    = 0;
        prev_in_fire = 0;
      end
      prev_phase = ph;
    end
  end

  // Downstream ready: always, random, or a 5-cycle stall after 6 outputs
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else if (stall_req && !stall_done && m_out_cnt == 6) begin
        bus.out_ready = 1'b0;
        stall_left = 4;
        stall_done = 1;
      end else if (rand_ready) begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  task automatic send_pix(input int p, input bit gaps);
    int n;
    bit ok, done;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_valid = 1'b0;
        bus.in_pixel = 3'($urandom_range(0, 7));
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_pixel = 3'(p);
    n = 0;
    done = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk); #1;
      if (ok) done = 1;
      n++;
    end
    if (!done) chk("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_phase(input int p, input int budget);
    int n = 0;
    while (int'(phase) != p && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_phase", int'(phase), p);
    @(posedge clk); #1;
  endtask

  task automatic wait_fd(input int budget);
    int n = 0;
    while (frame_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_seen", int'(frame_done), 1);
    @(posedge clk); #1;
  endtask

  task automatic collect(input int fr[NUM], input bit gaps);
    wait_phase(1, 100);
    for (int i = 0; i < NUM; i++) send_pix(fr[i], gaps);
  endtask

  task automatic run_frame(input int fr[NUM], input int lut_exp[L],
                           input bit gaps, input bit rnd, input bit stall);
    collect(fr, gaps);
    wait_phase(4, 200);
    for (int v = 0; v < L; v++) chk("model_lut", m_lut[v], lut_exp[v]);
    out_log.delete();
    rand_ready = rnd;
    stall_req  = stall;
    stall_done = 0;
    for (int i = 0; i < NUM; i++) send_pix(fr[i], 0);
    wait_fd(1000);
    rand_ready = 0;
    stall_req  = 0;
    chk("out_count", out_log.size(), NUM);
    for (int i = 0; i < NUM; i++)
      if (i < out_log.size()) chk("out_seq", out_log[i], lut_exp[fr[i]]);
  endtask

  task automatic check_reset_outputs();
    chk("rst_phase", int'(phase), 0);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_pixel", int'(bus.out_pixel), 0);
    chk("rst_lut_valid", int'(lut_valid), 0);
    chk("rst_frame_done", int'(frame_done), 0);
  endtask

  int frame_a [NUM] = '{0,1,2,3, 0,1,2,3, 0,1,2,3, 0,1,2,3};
  int frame_b [NUM] = '{default: 5};
  int frame_c [NUM] = '{0,7,0,7, 0,7,0,7, 0,7,0,7, 0,7,0,7};
  int frame_r [NUM] = '{0,1,2,3,4,5,6,7, 0,1,2,3,4,5,6,7};
  int lut_a   [L]   = '{0,2,4,7,7,7,7,7};
  int lut_c   [L]   = '{0,0,0,0,0,0,0,7};
  int lut_id  [L]   = '{0,1,2,3,4,5,6,7};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_pixel = '0;

    // Reset, then 8 clear cycles before collection opens
    repeat (3) @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("clear_phase", int'(phase), 0);
    end
    @(negedge clk);
    chk("collect_phase", int'(phase), 1);
    chk("collect_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;

    run_frame(frame_a, lut_a, 0, 0, 0);
    run_frame(frame_b, lut_id, 0, 0, 0);

    // Valid during clear must be ignored
    bus.in_valid = 1'b1;
    bus.in_pixel = 3'd3;
    repeat (4) begin @(posedge clk); #1; end
    bus.in_valid = 1'b0;
    run_frame(frame_c, lut_c, 1, 1, 0);

    run_frame(frame_a, lut_a, 0, 0, 1);

    // Abort a frame during LUT build, then a clean ramp frame
    collect(frame_a, 0);
    wait_phase(3, 100);
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    reset = 1'b0;
    run_frame(frame_r, lut_id, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/he_stream_eq.md
Name: he_stream_eq

Overview:
- Parametrised, streaming successor to the single-frame histogram-equalisation block.
- Frame pass 1: builds a histogram over NUM_PIXELS input pixels, then computes the CDF.
- From the CDF it builds the standard min-normalised mapping LUT with an exact sequential divider.
- Frame pass 2: remaps a second presentation of the frame with valid/ready handshakes on both sides, then re-arms for the next frame.

Parameters:
- PIX_W, 8, pixel bit width; number of bins L = 2^PIX_W.
- IMG_W, 660, frame width in pixels.
- IMG_H, 440, frame height in pixels.
- NUM_PIXELS, IMG_W*IMG_H, pixels per frame; must be >= 1.
- CNT_W, 19, width of histogram/CDF counters; must satisfy 2^CNT_W > NUM_PIXELS.

Ports:
- clk, input, 1, clock; all logic on rising edge.
- reset, input, 1, asynchronous, active-high.
- in_valid, input, 1, in_pixel valid.
- in_ready, output, 1, block accepts in_pixel this cycle.
- in_pixel, input, PIX_W, input pixel.
- out_valid, output, 1, out_pixel valid.
- out_ready, input, 1, downstream accepts out_pixel.
- out_pixel, output, PIX_W, remapped pixel.
- lut_valid, output, 1, high from LUT completion until end of the MAP phase.
- frame_done, output, 1, one-cycle pulse when the last remapped pixel is accepted downstream.
- phase, output, 3, current state encoding: CLEAR=0, COLLECT=1, CDF=2, LUT=3, MAP=4.

Behaviour:
- Reset: asynchronous. phase=CLEAR, bin counter=0, pixel counter=0, in_ready=0, out_valid=0, out_pixel=0, lut_valid=0, frame_done=0. Histogram/LUT contents are don't-care.
- Reset asserted mid-frame aborts the frame. No partial output is produced after reset deasserts.
- A transfer occurs on a cycle where valid && ready are both high at the rising edge.
- CLEAR: zero one histogram bin per cycle for L cycles; in_ready=0. After bin L-1, go to COLLECT.
- COLLECT: in_ready=1. Each accepted pixel increments hist[in_pixel] and the pixel counter.
  - Back-to-back accepts of the same value must count correctly (no read-modify-write hazard loss).
  - The transfer that brings the count to NUM_PIXELS is the last accepted. Go to CDF and drop in_ready the next cycle.
  - in_valid with in_ready=0 is ignored and not counted.
- CDF: one bin per cycle, cdf[0]=hist[0], cdf[k]=cdf[k-1]+hist[k]; L cycles.
  - cdf_min = first nonzero cdf value encountered in ascending bin order.
  - Accumulator is CNT_W wide and never overflows given the CNT_W rule.
- LUT: for each bin v, D = NUM_PIXELS - cdf_min.
  - If D == 0 (single-valued frame): lut[v] = v (identity).
  - Otherwise lut[v] = floor(((cdf[v]-cdf_min)*(L-1)) / D), with cdf[v]<cdf_min treated as 0.
  - Product is CNT_W+PIX_W bits wide; quotient always fits PIX_W bits.
  - Division is a restoring divider: exactly PIX_W+1 cycles per bin (1 load + PIX_W iterations), so LUT takes L*(PIX_W+1) cycles.
  - Then set lut_valid=1 and go to MAP.
- MAP: single output register stage.
  - in_ready = !out_valid || out_ready.
  - On input transfer, the next cycle gives out_valid=1, out_pixel=lut[in_pixel]. Latency is 1 cycle; full throughput when out_ready stays high.
  - out_pixel/out_valid hold stable while out_valid && !out_ready.
  - After NUM_PIXELS input transfers, in_ready=0.
  - When the final output transfers, pulse frame_done for 1 cycle, clear lut_valid, and go to CLEAR.
  - Simultaneous input accept and output drain in the same cycle is legal and must not drop or duplicate pixels.
- Counters wrap to 0 exactly at the frame boundary; no other wrap is permitted.

Test Plan (IMG_W=4, IMG_H=4, PIX_W=3, CNT_W=5 unless noted):
- Reset then idle: phase=0 for 8 cycles, then phase=1 and in_ready=1; all outputs 0 during reset.
- Collect 4 each of values 0,1,2,3 -> cdf_min=4, D=12. LUT = 0,2,4,7,7,7,7,7. Replaying the frame outputs 0,2,4,7 for inputs 0,1,2,3 with 1-cycle latency.
- All 16 pixels value 5 -> D=0, identity LUT. Replay outputs 5 for all pixels; frame_done pulses once after the 16th output.
- Eight 0s and eight 7s, in_valid toggled randomly in COLLECT -> only transfers counted. LUT[0..6]=0, LUT[7]=7.
- MAP with out_ready held low 5 cycles mid-frame -> out_pixel stable, in_ready=0 while the register is full, no loss or duplication. Output count is exactly 16.
- Assert reset during LUT phase, then run a full frame of ramp values (two each of 0..7) -> identity mapping, no stale output from the aborted frame. Default params: cycle count of the LUT phase = 256*9.
